// File: rtl/spi_nor_responder.sv
// spi_nor_responder: byte-wide SPI NOR flash responder.
// Command + 3-byte address, then a 32-bit word read out or written in.
module spi_nor_responder #(
  parameter int         AW     = 8,
  parameter logic [7:0] CMD_RD = 8'h01,
  parameter logic [7:0] CMD_WR = 8'h02
) (
  input  logic       s_clk,
  input  logic       rst,
  input  logic       s_css,
  input  logic [7:0] s_mosi,
  output logic [7:0] s_miso,
  output logic       busy,
  output logic       cmd_err,
  output logic       wr_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA,
    ST_DONE,
    ST_IGNORE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;
  logic        r_is_wr;
  logic        w_is_wr_nxt;
  logic [23:0] r_addr;
  logic [23:0] w_addr_nxt;
  logic [23:0] r_shift;
  logic [23:0] w_shift_nxt;
  logic [23:0] r_stage;
  logic [23:0] w_stage_nxt;
  logic [7:0]  r_miso;
  logic [7:0]  w_miso_nxt;
  logic        r_cmd_err;
  logic        w_cmd_err_nxt;
  logic        r_wr_done;
  logic        w_wr_done_nxt;
  logic        w_we;
  logic [23:0] w_addr_full;
  logic [31:0] w_rword;
  logic [31:0] w_wdata;
  logic        w_unused_addr;

  logic [31:0] r_mem [2**AW];

  // Address as it stands once the current byte is shifted in.
  assign w_addr_full   = {r_addr[15:0], s_mosi};
  assign w_rword       = r_mem[w_addr_full[AW-1:0]];
  assign w_wdata       = {r_stage, s_mosi};
  // Upper address bits are accepted but play no part in indexing.
  assign w_unused_addr = ^r_addr;

  assign s_miso  = r_miso;
  assign cmd_err = r_cmd_err;
  assign wr_done = r_wr_done;
  assign busy    = (r_state == ST_ADDR) ||
                   (r_state == ST_RDATA) ||
                   (r_state == ST_WDATA);

  // State and datapath registers; outputs clear asynchronously on reset.
  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 2'd0;
      r_is_wr   <= 1'b0;
      r_addr    <= 24'd0;
      r_shift   <= 24'd0;
      r_stage   <= 24'd0;
      r_miso    <= 8'h00;
      r_cmd_err <= 1'b0;
      r_wr_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_is_wr   <= w_is_wr_nxt;
      r_addr    <= w_addr_nxt;
      r_shift   <= w_shift_nxt;
      r_stage   <= w_stage_nxt;
      r_miso    <= w_miso_nxt;
      r_cmd_err <= w_cmd_err_nxt;
      r_wr_done <= w_wr_done_nxt;
    end
  end

  // Word array; contents survive reset and only change on a full write.
  always_ff @(posedge s_clk) begin
    if (w_we) begin
      r_mem[r_addr[AW-1:0]] <= w_wdata;
    end
  end

  // Next-state, datapath and output decode; deselect overrides everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_is_wr_nxt   = r_is_wr;
    w_addr_nxt    = r_addr;
    w_shift_nxt   = r_shift;
    w_stage_nxt   = r_stage;
    w_miso_nxt    = 8'h00;
    w_cmd_err_nxt = r_cmd_err;
    w_wr_done_nxt = 1'b0;
    w_we          = 1'b0;
    if (s_css) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 2'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = 2'd0;
          if ((s_mosi == CMD_RD) || (s_mosi == CMD_WR)) begin
            w_state_nxt   = ST_ADDR;
            w_is_wr_nxt   = (s_mosi == CMD_WR);
            w_cmd_err_nxt = 1'b0;
          end else begin
            w_state_nxt   = ST_IGNORE;
            w_cmd_err_nxt = 1'b1;
          end
        end
        ST_ADDR: begin
          w_addr_nxt = w_addr_full;
          w_cnt_nxt  = r_cnt + 2'd1;
          if (r_cnt == 2'd2) begin
            w_cnt_nxt = 2'd0;
            if (r_is_wr) begin
              w_state_nxt = ST_WDATA;
            end else begin
              w_state_nxt = ST_RDATA;
              w_miso_nxt  = w_rword[31:24];
              w_shift_nxt = w_rword[23:0];
            end
          end
        end
        ST_RDATA: begin
          w_miso_nxt  = r_shift[23:16];
          w_shift_nxt = {r_shift[15:0], 8'h00};
          w_cnt_nxt   = r_cnt + 2'd1;
          if (r_cnt == 2'd2) begin
            w_cnt_nxt   = 2'd0;
            w_state_nxt = ST_DONE;
          end
        end
        ST_WDATA: begin
          w_stage_nxt = {r_stage[15:0], s_mosi};
          w_cnt_nxt   = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            w_cnt_nxt     = 2'd0;
            w_we          = 1'b1;
            w_wr_done_nxt = 1'b1;
            w_state_nxt   = ST_DONE;
          end
        end
        ST_DONE, ST_IGNORE: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_nor_responder.sv
// tb_spi_nor_responder: directed bench with a read-data scoreboard.
// Expected words come from a bench-side model of the array.
module tb_spi_nor_responder;

  logic       s_clk = 1'b0;
  logic       rst;
  logic       s_css;
  logic [7:0] s_mosi;
  logic [7:0] s_miso;
  logic       busy;
  logic       cmd_err;
  logic       wr_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model [256];
  logic [31:0] rd_q [$];

  spi_nor_responder #(
    .AW(8),
    .CMD_RD(8'h01),
    .CMD_WR(8'h02)
  ) dut (
    .s_clk  (s_clk),
    .rst    (rst),
    .s_css  (s_css),
    .s_mosi (s_mosi),
    .s_miso (s_miso),
    .busy   (busy),
    .cmd_err(cmd_err),
    .wr_done(wr_done)
  );

  always #5 s_clk = ~s_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one byte, then settle just after the rising edge.
  task automatic step(input logic css, input logic [7:0] mosi);
    @(negedge s_clk);
    s_css  = css;
    s_mosi = mosi;
    @(posedge s_clk);
    #1;
  endtask

  task automatic deselect();
    step(1'b1, 8'h00);
    chk("desel_busy", {31'd0, busy}, 32'd0);
    chk("desel_miso", {24'd0, s_miso}, 32'd0);
  endtask

  // ndata data bytes; if css_last, the 4th byte comes with deselect.
  task automatic do_write(input int idx, input logic [31:0] d,
                          input int ndata, input bit css_last);
    logic [7:0] ib;
    logic       full;
    ib = idx[7:0];
    full = (ndata == 4) && !css_last;
    step(1'b0, 8'h02);
    chk("wr_busy_e1", {31'd0, busy}, 32'd1);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    step(1'b0, ib);
    for (int k = 0; k < ndata; k++) begin
      step((k == 3) && css_last, d[31-8*k -: 8]);
      chk("wr_done", {31'd0, wr_done},
          {31'd0, (k == 3) && full});
    end
    if (full) begin
      chk("wr_busy_e8", {31'd0, busy}, 32'd0);
      model[idx] = d;
    end
  endtask

  task automatic do_read(input int idx, input int nedges);
    logic [31:0] got;
    logic [31:0] exp;
    logic [7:0]  ib;
    ib = idx[7:0];
    rd_q.push_back(model[idx]);
    step(1'b0, 8'h01);
    chk("rd_cmd_err", {31'd0, cmd_err}, 32'd0);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    step(1'b0, ib);
    chk("rd_busy_e4", {31'd0, busy}, 32'd1);
    got[31:24] = s_miso;
    step(1'b0, 8'h00);
    got[23:16] = s_miso;
    step(1'b0, 8'h00);
    got[15:8] = s_miso;
    step(1'b0, 8'h00);
    got[7:0] = s_miso;
    chk("rd_busy_e7", {31'd0, busy}, 32'd0);
    exp = rd_q.pop_front();
    chk("rd_word", got, exp);
    for (int e = 8; e <= nedges; e++) begin
      step(1'b0, 8'hFF);
      chk("rd_tail_miso", {24'd0, s_miso}, 32'd0);
      chk("rd_tail_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    rst    = 1'b1;
    s_css  = 1'b1;
    s_mosi = 8'h00;
    repeat (2) @(posedge s_clk);
    #1;
    chk("rst_miso", {24'd0, s_miso}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    chk("rst_wr_done", {31'd0, wr_done}, 32'd0);
    @(negedge s_clk);
    rst = 1'b0;
    step(1'b1, 8'h00);

    // Write then read one index.
    do_write(5, 32'hDEADBEEF, 4, 1'b0);
    deselect();
    chk("wr_done_once", {31'd0, wr_done}, 32'd0);
    do_read(5, 8);
    deselect();

    // Two indices, no aliasing.
    do_write(8'h01, 32'h11223344, 4, 1'b0);
    deselect();
    do_write(8'hFF, 32'hA5A5A5A5, 4, 1'b0);
    deselect();
    do_read(8'h01, 8);
    deselect();
    do_read(8'hFF, 8);
    deselect();

    // Aborted write leaves the prior word.
    do_write(7, 32'h01020304, 4, 1'b0);
    deselect();
    do_write(7, 32'hCAFEF00D, 2, 1'b0);
    deselect();
    chk("abort_wr_done", {31'd0, wr_done}, 32'd0);
    do_read(7, 8);
    deselect();

    // Deselect on the 4th data byte wins.
    do_write(9, 32'h55667788, 4, 1'b0);
    deselect();
    do_write(9, 32'h99AABBCC, 4, 1'b1);
    chk("css_last_wr_done", {31'd0, wr_done}, 32'd0);
    step(1'b1, 8'h00);
    chk("css_last_wr_done2", {31'd0, wr_done}, 32'd0);
    do_read(9, 8);
    deselect();

    // Bad command.
    step(1'b0, 8'h5A);
    chk("bad_cmd_err", {31'd0, cmd_err}, 32'd1);
    chk("bad_busy", {31'd0, busy}, 32'd0);
    chk("bad_miso", {24'd0, s_miso}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, (k == 3) ? 8'hFF : 8'h00);
      chk("bad_tail_busy", {31'd0, busy}, 32'd0);
      chk("bad_tail_miso", {24'd0, s_miso}, 32'd0);
      chk("bad_tail_err", {31'd0, cmd_err}, 32'd1);
    end
    deselect();
    chk("bad_err_sticky", {31'd0, cmd_err}, 32'd1);
    do_read(5, 8);
    deselect();

    // Reset between edges 6 and 7 of a write.
    do_write(3, 32'h0A0B0C0D, 4, 1'b0);
    deselect();
    do_write(3, 32'hFFEEDDCC, 2, 1'b0);
    chk("rstw_busy_pre", {31'd0, busy}, 32'd1);
    @(negedge s_clk);
    rst = 1'b1;
    #1;
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_miso", {24'd0, s_miso}, 32'd0);
    chk("rstw_wr_done", {31'd0, wr_done}, 32'd0);
    chk("rstw_cmd_err", {31'd0, cmd_err}, 32'd0);
    s_css  = 1'b0;
    s_mosi = 8'hEE;
    repeat (2) @(posedge s_clk);
    @(negedge s_clk);
    rst = 1'b0;
    deselect();
    do_read(3, 8);
    deselect();

    // Read held selected for 12 edges.
    do_read(8'hFF, 12);
    deselect();

    chk("rd_q_empty", rd_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
